// File: rtl/pll_gain_sched.sv
// PLL loop-gain scheduler: climbs kp/ki shift gears on sustained lock, falls back to gear 0 on sustained unlock.
// Latency: gear, kp/ki and gear_change are registered one cycle after the deciding strobe. No backpressure.
module pll_gain_sched #(
    parameter int NUM_GEARS = 4,
    parameter int SHIFT_W   = 5,
    parameter int TMR_W     = 8,
    localparam int GEAR_W   = (NUM_GEARS > 2) ? $clog2(NUM_GEARS) : 1
) (
    input  logic                         sys_clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic                         sample_en,
    input  logic                         lock_in,
    input  logic                         force_acq,
    input  logic [NUM_GEARS*SHIFT_W-1:0] kp_table,
    input  logic [NUM_GEARS*SHIFT_W-1:0] ki_table,
    input  logic [TMR_W-1:0]             lock_dwell,
    input  logic [TMR_W-1:0]             unlock_dwell,
    output logic [SHIFT_W-1:0]           kp_shift,
    output logic [SHIFT_W-1:0]           ki_shift,
    output logic [GEAR_W-1:0]            gear,
    output logic [1:0]                   state,
    output logic                         gear_change
);

    typedef enum logic [1:0] {
        ST_ACQ   = 2'd0,
        ST_TRACK = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic [GEAR_W-1:0] TOP_GEAR = GEAR_W'(NUM_GEARS - 1);

    state_t              r_state;
    logic [GEAR_W-1:0]   r_gear;
    logic [TMR_W-1:0]    r_lock_cnt;
    logic [TMR_W-1:0]    r_unlock_cnt;
    logic                r_gear_change;
    logic [SHIFT_W-1:0]  r_kp;
    logic [SHIFT_W-1:0]  r_ki;

    state_t              w_state_nxt;
    logic [GEAR_W-1:0]   w_gear_nxt;
    logic [GEAR_W-1:0]   w_gear_inc;
    logic [TMR_W-1:0]    w_lock_nxt;
    logic [TMR_W-1:0]    w_unlock_nxt;
    logic                w_gc_nxt;
    logic [TMR_W-1:0]    w_lock_eff;
    logic [TMR_W-1:0]    w_unlock_eff;
    logic [TMR_W:0]      w_lock_inc;
    logic [TMR_W:0]      w_unlock_inc;
    logic [TMR_W-1:0]    w_lock_sat;
    logic [TMR_W-1:0]    w_unlock_sat;
    logic                w_lock_hit;
    logic                w_unlock_hit;
    logic                w_unlock_one;

    logic [SHIFT_W-1:0]  w_kp_arr [NUM_GEARS];
    logic [SHIFT_W-1:0]  w_ki_arr [NUM_GEARS];

    for (genvar g = 0; g < NUM_GEARS; g++) begin : g_unpack
        assign w_kp_arr[g] = kp_table[g*SHIFT_W +: SHIFT_W];
        assign w_ki_arr[g] = ki_table[g*SHIFT_W +: SHIFT_W];
    end

    // A zero dwell behaves as a single-strobe dwell.
    assign w_lock_eff   = (lock_dwell   == '0) ? TMR_W'(1) : lock_dwell;
    assign w_unlock_eff = (unlock_dwell == '0) ? TMR_W'(1) : unlock_dwell;

    assign w_lock_inc   = {1'b0, r_lock_cnt}   + {{TMR_W{1'b0}}, 1'b1};
    assign w_unlock_inc = {1'b0, r_unlock_cnt} + {{TMR_W{1'b0}}, 1'b1};
    assign w_lock_sat   = (&r_lock_cnt)   ? r_lock_cnt   : w_lock_inc[TMR_W-1:0];
    assign w_unlock_sat = (&r_unlock_cnt) ? r_unlock_cnt : w_unlock_inc[TMR_W-1:0];
    assign w_lock_hit   = (w_lock_inc   >= {1'b0, w_lock_eff});
    assign w_unlock_hit = (w_unlock_inc >= {1'b0, w_unlock_eff});
    assign w_unlock_one = (w_unlock_eff == TMR_W'(1));
    assign w_gear_inc   = r_gear + GEAR_W'(1);

    always_comb begin
        w_state_nxt  = r_state;
        w_gear_nxt   = r_gear;
        w_lock_nxt   = r_lock_cnt;
        w_unlock_nxt = r_unlock_cnt;
        w_gc_nxt     = 1'b0;
        if (force_acq) begin
            w_state_nxt  = ST_ACQ;
            w_gear_nxt   = '0;
            w_lock_nxt   = '0;
            w_unlock_nxt = '0;
            w_gc_nxt     = (r_gear != '0);
        end else if (enable && sample_en) begin
            case (r_state)
                ST_ACQ: begin
                    if (lock_in) begin
                        w_unlock_nxt = '0;
                        if (w_lock_hit && (r_gear != TOP_GEAR)) begin
                            w_lock_nxt = '0;
                            w_gear_nxt = w_gear_inc;
                            w_gc_nxt   = 1'b1;
                            if (w_gear_inc == TOP_GEAR) begin
                                w_state_nxt = ST_TRACK;
                            end
                        end else begin
                            w_lock_nxt = w_lock_sat;
                        end
                    end else begin
                        w_lock_nxt = '0;
                        if (w_unlock_hit) begin
                            w_unlock_nxt = '0;
                            w_gear_nxt   = '0;
                            w_gc_nxt     = (r_gear != '0);
                        end else begin
                            w_unlock_nxt = w_unlock_sat;
                        end
                    end
                end
                ST_TRACK: begin
                    if (!lock_in) begin
                        if (w_unlock_one) begin
                            w_state_nxt  = ST_ACQ;
                            w_gear_nxt   = '0;
                            w_lock_nxt   = '0;
                            w_unlock_nxt = '0;
                            w_gc_nxt     = 1'b1;
                        end else begin
                            w_state_nxt  = ST_WAIT;
                            w_unlock_nxt = TMR_W'(1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (lock_in) begin
                        w_state_nxt  = ST_TRACK;
                        w_unlock_nxt = '0;
                    end else if (w_unlock_hit) begin
                        w_state_nxt  = ST_ACQ;
                        w_gear_nxt   = '0;
                        w_lock_nxt   = '0;
                        w_unlock_nxt = '0;
                        w_gc_nxt     = 1'b1;
                    end else begin
                        w_unlock_nxt = w_unlock_sat;
                    end
                end
                default: begin
                    w_state_nxt  = ST_ACQ;
                    w_gear_nxt   = '0;
                    w_lock_nxt   = '0;
                    w_unlock_nxt = '0;
                    w_gc_nxt     = (r_gear != '0);
                end
            endcase
        end
    end

    // kp/ki reload every cycle so table edits propagate even while the gear is steady.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_ACQ;
            r_gear        <= '0;
            r_lock_cnt    <= '0;
            r_unlock_cnt  <= '0;
            r_gear_change <= 1'b0;
            r_kp          <= '0;
            r_ki          <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_gear        <= w_gear_nxt;
            r_lock_cnt    <= w_lock_nxt;
            r_unlock_cnt  <= w_unlock_nxt;
            r_gear_change <= w_gc_nxt;
            r_kp          <= w_kp_arr[w_gear_nxt];
            r_ki          <= w_ki_arr[w_gear_nxt];
        end
    end

    assign kp_shift    = r_kp;
    assign ki_shift    = r_ki;
    assign gear        = r_gear;
    assign state       = r_state;
    assign gear_change = r_gear_change;

endmodule

// File: tb/tb_pll_gain_sched.sv
// Bench for pll_gain_sched: directed scenarios then random traffic, all checked every cycle against a behavioural model.
module tb_pll_gain_sched;

    logic        sys_clk;
    logic        rst_n;
    logic        enable;
    logic        sample_en;
    logic        lock_in;
    logic        force_acq;
    logic [19:0] kp_table;
    logic [19:0] ki_table;
    logic [7:0]  lock_dwell;
    logic [7:0]  unlock_dwell;
    logic [4:0]  kp_shift;
    logic [4:0]  ki_shift;
    logic [1:0]  gear;
    logic [1:0]  state;
    logic        gear_change;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    // Model: mode 0 climbing, 1 locked at top, 2 debouncing unlock at top.
    int       m_gear, m_mode, m_lc, m_uc;
    bit       m_gc;
    int       m_kp, m_ki;

    pll_gain_sched dut (
        .sys_clk      (sys_clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .sample_en    (sample_en),
        .lock_in      (lock_in),
        .force_acq    (force_acq),
        .kp_table     (kp_table),
        .ki_table     (ki_table),
        .lock_dwell   (lock_dwell),
        .unlock_dwell (unlock_dwell),
        .kp_shift     (kp_shift),
        .ki_shift     (ki_shift),
        .gear         (gear),
        .state        (state),
        .gear_change  (gear_change)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_gear = 0; m_mode = 0; m_lc = 0; m_uc = 0;
        m_gc = 0; m_kp = 0; m_ki = 0;
    endtask

    task automatic model_edge();
        int el, eu, ng;
        if (!rst_n) return;
        el = (lock_dwell == 0) ? 1 : int'(lock_dwell);
        eu = (unlock_dwell == 0) ? 1 : int'(unlock_dwell);
        ng = m_gear;
        if (force_acq) begin
            ng = 0; m_mode = 0; m_lc = 0; m_uc = 0;
        end else if (enable && sample_en) begin
            if (m_mode == 0) begin
                if (lock_in) begin
                    m_uc = 0;
                    m_lc++;
                    if (m_lc >= el) begin
                        ng = m_gear + 1; m_lc = 0;
                        if (ng == 3) m_mode = 1;
                    end
                end else begin
                    m_lc = 0;
                    m_uc++;
                    if (m_uc >= eu) begin ng = 0; m_uc = 0; end
                end
            end else if (m_mode == 1) begin
                if (!lock_in) begin
                    if (eu == 1) begin ng = 0; m_mode = 0; m_lc = 0; m_uc = 0; end
                    else begin m_uc = 1; m_mode = 2; end
                end
            end else begin
                if (lock_in) begin
                    m_uc = 0; m_mode = 1;
                end else begin
                    m_uc++;
                    if (m_uc >= eu) begin ng = 0; m_mode = 0; m_lc = 0; m_uc = 0; end
                end
            end
        end
        m_gc   = (ng != m_gear);
        m_gear = ng;
        m_kp   = int'(kp_table[ng*5 +: 5]);
        m_ki   = int'(ki_table[ng*5 +: 5]);
    endtask

    task automatic check_all();
        chk("gear", 32'(gear), 32'(m_gear));
        chk("state", 32'(state), 32'(m_mode));
        chk("kp_shift", 32'(kp_shift), 32'(m_kp));
        chk("ki_shift", 32'(ki_shift), 32'(m_ki));
        chk("gear_change", 32'(gear_change), 32'(m_gc));
    endtask

    task automatic step();
        @(posedge sys_clk);
        model_edge();
        #1;
        if (gear_change === 1'b1) pulses++;
        check_all();
    endtask

    task automatic strobe(input bit lk);
        sample_en = 1'b1;
        lock_in   = lk;
        step();
        sample_en = 1'b0;
        repeat (7) step();
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; sample_en = 1'b0; lock_in = 1'b0; force_acq = 1'b0;
        kp_table = {5'd13, 5'd11, 5'd9, 5'd7};
        ki_table = {5'd3, 5'd4, 5'd5, 5'd6};
        lock_dwell = 8'd4; unlock_dwell = 8'd3;
        model_reset();
        #3;
        check_all();
        chk("reset_kp_zero", 32'(kp_shift), 32'd0);
        step(); step();
        rst_n = 1'b1;
        step();
        chk("kp_after_release", 32'(kp_shift), 32'd7);
        chk("ki_after_release", 32'(ki_shift), 32'd6);

        // Climb through the gears with dwell 4.
        enable = 1'b1;
        pulses = 0;
        for (int i = 1; i <= 12; i++) begin
            strobe(1'b1);
            if (i == 4)  chk("gear_after_4", 32'(gear), 32'd1);
            if (i == 8)  chk("gear_after_8", 32'(gear), 32'd2);
            if (i == 12) begin
                chk("gear_after_12", 32'(gear), 32'd3);
                chk("track_after_12", 32'(state), 32'd1);
                chk("kp_top", 32'(kp_shift), 32'd13);
            end
        end
        chk("climb_pulses", 32'(pulses), 32'd3);

        // Short unlock glitch at the top gear is debounced.
        pulses = 0;
        strobe(1'b0);
        chk("wait_after_unlock", 32'(state), 32'd2);
        strobe(1'b0);
        strobe(1'b1);
        chk("track_after_relock", 32'(state), 32'd1);
        chk("gear_held", 32'(gear), 32'd3);
        chk("glitch_no_pulse", 32'(pulses), 32'd0);

        // Sustained unlock drops to gear 0.
        strobe(1'b0);
        strobe(1'b0);
        sample_en = 1'b1; lock_in = 1'b0;
        step();
        chk("drop_gear", 32'(gear), 32'd0);
        chk("drop_state", 32'(state), 32'd0);
        chk("drop_kp", 32'(kp_shift), 32'd7);
        chk("drop_pulse", 32'(gear_change), 32'd1);
        sample_en = 1'b0;
        repeat (3) step();

        // force_acq beats a simultaneous stepping strobe at gear 2.
        for (int i = 0; i < 11; i++) strobe(1'b1);
        chk("force_pre_gear", 32'(gear), 32'd2);
        sample_en = 1'b1; lock_in = 1'b1; force_acq = 1'b1;
        step();
        chk("force_gear", 32'(gear), 32'd0);
        chk("force_state", 32'(state), 32'd0);
        chk("force_pulse", 32'(gear_change), 32'd1);
        step();
        chk("force_at0_no_pulse", 32'(gear_change), 32'd0);
        chk("force_at0_gear", 32'(gear), 32'd0);
        force_acq = 1'b0; sample_en = 1'b0;
        repeat (3) step();

        // Zero dwells act as one.
        lock_dwell = 8'd0; unlock_dwell = 8'd0;
        for (int i = 0; i < 3; i++) strobe(1'b1);
        chk("zero_dwell_gear", 32'(gear), 32'd3);
        chk("zero_dwell_track", 32'(state), 32'd1);
        sample_en = 1'b1; lock_in = 1'b0;
        step();
        chk("zero_dwell_drop", 32'(gear), 32'd0);
        chk("zero_dwell_acq", 32'(state), 32'd0);
        chk("zero_dwell_pulse", 32'(gear_change), 32'd1);
        sample_en = 1'b0;
        repeat (3) step();

        // Reset mid-debounce.
        lock_dwell = 8'd1; unlock_dwell = 8'd3;
        for (int i = 0; i < 3; i++) strobe(1'b1);
        strobe(1'b0);
        strobe(1'b0);
        chk("pre_reset_wait", 32'(state), 32'd2);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        step();
        rst_n = 1'b1;
        sample_en = 1'b1; lock_in = 1'b0;
        step();
        chk("post_reset_gear", 32'(gear), 32'd0);
        chk("post_reset_no_pulse", 32'(gear_change), 32'd0);
        chk("post_reset_kp", 32'(kp_shift), 32'd7);
        sample_en = 1'b0;
        step();

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            enable    = ($urandom_range(9) != 0);
            sample_en = ($urandom_range(2) == 0);
            lock_in   = ($urandom_range(4) != 0);
            force_acq = ($urandom_range(80) == 0);
            if ($urandom_range(150) == 0) begin
                lock_dwell   = 8'($urandom_range(4));
                unlock_dwell = 8'($urandom_range(3));
            end
            if ($urandom_range(200) == 0) begin
                kp_table = 20'($urandom);
                ki_table = 20'($urandom);
            end
            if ($urandom_range(700) == 0) begin
                rst_n = 1'b0;
                model_reset();
                step();
                rst_n = 1'b1;
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
